// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        B_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int DMEM_AW               = 16;
    localparam int DMEM_DW               = 16;
    localparam int DMEM_LEN_W            = 2;
    localparam int STARVE_LIMIT_DEFAULT  = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles requester A, requester B and the data-memory port of the arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int DW    = DMEM_DW,
    parameter int LEN_W = DMEM_LEN_W
);

    logic             a_req;
    logic             a_we;
    logic [AW-1:0]    a_addr;
    logic [DW-1:0]    a_wdata;
    logic             a_gnt;
    logic             a_rvalid;
    logic [DW-1:0]    a_rdata;

    logic             b_req;
    logic             b_we;
    logic [AW-1:0]    b_addr;
    logic [LEN_W-1:0] b_len;
    logic [DW-1:0]    b_wdata;
    logic             b_gnt;
    logic             b_rvalid;
    logic [DW-1:0]    b_rdata;
    logic             b_done;

    logic             mem_read_enable;
    logic             mem_write_enable;
    logic [AW-1:0]    mem_read_addr;
    logic [AW-1:0]    mem_write_addr;
    logic [DW-1:0]    mem_write_data;
    logic [DW-1:0]    mem_read_data;

    logic             busy;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_len, b_wdata,
        output b_gnt, b_rvalid, b_rdata, b_done,
        output mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_read_data,
        output busy
    );

    // Requesters plus memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_len, b_wdata,
        input  b_gnt, b_rvalid, b_rdata, b_done,
        input  mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        output mem_read_data,
        input  busy
    );

endinterface

// File: rtl/dmem_arbiter_burst_ctr.sv
// Burst beat address generator: holds the next beat address (wrapping) and the
// number of beats still to issue, flagging when the next beat is the last one.
module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int AW    = DMEM_AW,
    parameter int LEN_W = DMEM_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [AW-1:0]    i_base,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_step,
    output logic [AW-1:0]    o_addr,
    output logic             o_last
);

    logic [AW-1:0]    r_addr;
    logic [LEN_W-1:0] r_rem;

    // Beat 0 goes out directly from the request, so loading starts at base+1
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_addr <= i_base + AW'(1);
            r_rem  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - LEN_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_rem == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Fixed-priority data-memory arbiter: A wins ties unless B has starved,
// B bursts lock the memory until their last beat is issued.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DMEM_AW,
    parameter int DW           = DMEM_DW,
    parameter int LEN_W        = DMEM_LEN_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_burst_we;

    logic              w_starved;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_acc;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_wdata;
    owner_t            w_owner;
    logic              w_last;
    logic              w_load;
    logic              w_step;
    logic [AW-1:0]     w_ctr_addr;
    logic              w_ctr_last;

    logic              r_mem_re;
    logic              r_mem_we;
    logic [AW-1:0]     r_mem_raddr;
    logic [AW-1:0]     r_mem_waddr;
    logic [DW-1:0]     r_mem_wdata;
    owner_t            r_owner;
    logic              r_cmd_last;

    logic              r_a_rvalid;
    logic [DW-1:0]     r_a_rdata;
    logic              r_b_rvalid;
    logic [DW-1:0]     r_b_rdata;
    logic              r_b_done;

    dmem_burst_ctr #(
        .AW    (AW),
        .LEN_W (LEN_W)
    ) u_burst_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_base (bus.b_addr),
        .i_len  (bus.b_len),
        .i_step (w_step),
        .o_addr (w_ctr_addr),
        .o_last (w_ctr_last)
    );

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        w_state_nxt = r_state;
        w_a_gnt     = 1'b0;
        w_b_gnt     = 1'b0;
        w_acc       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_owner     = OWN_A;
        w_last      = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                w_a_gnt = bus.a_req && !(bus.b_req && w_starved);
                w_b_gnt = bus.b_req && !w_a_gnt;
                if (w_a_gnt) begin
                    w_acc   = 1'b1;
                    w_we    = bus.a_we;
                    w_addr  = bus.a_addr;
                    w_wdata = bus.a_wdata;
                    w_owner = OWN_A;
                end else if (w_b_gnt) begin
                    w_acc   = 1'b1;
                    w_we    = bus.b_we;
                    w_addr  = bus.b_addr;
                    w_wdata = bus.b_wdata;
                    w_owner = OWN_B;
                    if (bus.b_len != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = B_BURST;
                    end else begin
                        w_last = 1'b1;
                    end
                end
            end
            B_BURST: begin
                w_b_gnt = 1'b1;
                w_acc   = 1'b1;
                w_we    = r_burst_we;
                w_addr  = w_ctr_addr;
                w_wdata = bus.b_wdata;
                w_owner = OWN_B;
                w_step  = 1'b1;
                if (w_ctr_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // Starvation counter only tracks IDLE cycles where B is waiting behind A
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_burst_we   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_burst_we <= bus.b_we;
            end
            if (!bus.b_req || (r_state == IDLE && w_b_gnt)) begin
                r_starve_cnt <= '0;
            end else if (r_state == IDLE && w_a_gnt && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_owner     <= OWN_A;
            r_cmd_last  <= 1'b0;
        end else begin
            r_mem_re   <= w_acc && !w_we;
            r_mem_we   <= w_acc && w_we;
            r_cmd_last <= w_last;
            if (w_acc && !w_we) begin
                r_mem_raddr <= w_addr;
                r_owner     <= w_owner;
            end
            if (w_acc && w_we) begin
                r_mem_waddr <= w_addr;
                r_mem_wdata <= w_wdata;
            end
        end
    end

    // Read data is steered purely by the owner tag captured with the command
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= '0;
            r_b_done   <= 1'b0;
        end else begin
            r_a_rvalid <= r_mem_re && (r_owner == OWN_A);
            r_b_rvalid <= r_mem_re && (r_owner == OWN_B);
            r_b_done   <= r_cmd_last;
            if (r_mem_re && r_owner == OWN_A) begin
                r_a_rdata <= bus.mem_read_data;
            end
            if (r_mem_re && r_owner == OWN_B) begin
                r_b_rdata <= bus.mem_read_data;
            end
        end
    end

    assign bus.a_gnt            = w_a_gnt;
    assign bus.b_gnt            = w_b_gnt;
    assign bus.a_rvalid         = r_a_rvalid;
    assign bus.a_rdata          = r_a_rdata;
    assign bus.b_rvalid         = r_b_rvalid;
    assign bus.b_rdata          = r_b_rdata;
    assign bus.b_done           = r_b_done;
    assign bus.mem_read_enable  = r_mem_re;
    assign bus.mem_write_enable = r_mem_we;
    assign bus.mem_read_addr    = r_mem_raddr;
    assign bus.mem_write_addr   = r_mem_waddr;
    assign bus.mem_write_data   = r_mem_wdata;
    assign bus.busy             = (r_state == B_BURST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LEN_W = 2;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dmem_arbiter_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

    dmem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .LEN_W        (LEN_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    // Data memory: write at rising edge, read data presented at falling edge
    logic [DW-1:0] memArr [0:65535];
    always @(posedge clk) if (bus.mem_write_enable) memArr[bus.mem_write_addr] <= bus.mem_write_data;
    always @(negedge clk) bus.mem_read_data <= bus.mem_read_enable ? memArr[bus.mem_read_addr] : 'x;

    // Reference model: pending command of the current cycle, burst beats left, wait count
    typedef struct packed {
        logic        valid;
        logic        we;
        logic        ownerB;
        logic        last;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    logic [15:0] refMem [0:65535];
    cmd_t        curCmd;
    int          burstLeft = 0;
    int          waitCnt   = 0;
    int          cyc       = 0;
    logic [15:0] burstAddr;
    logic        burstWe;
    logic        expAV, expBV, expDone;
    logic [15:0] expAData, expBData;
    bit          modelReady = 0;

    function automatic void modelGrants(output logic ga, output logic gb);
        if (burstLeft > 0) begin
            ga = 1'b0;
            gb = 1'b1;
        end else begin
            ga = bus.a_req && !(bus.b_req && waitCnt == LIMIT);
            gb = bus.b_req && !ga;
        end
    endfunction

    always @(posedge clk) begin
        logic ga, gb;
        cmd_t nxt;
        modelGrants(ga, gb);
        cyc++;
        if (curCmd.valid && curCmd.we) refMem[curCmd.addr] = curCmd.data;
        if (!rst) begin
            burstLeft = 0;
            waitCnt   = 0;
            curCmd    = '0;
            expAV     = 1'b0;
            expBV     = 1'b0;
            expDone   = 1'b0;
            expAData  = '0;
            expBData  = '0;
        end else begin
            expAV   = curCmd.valid && !curCmd.we && !curCmd.ownerB;
            expBV   = curCmd.valid && !curCmd.we && curCmd.ownerB;
            expDone = curCmd.valid && curCmd.last;
            if (expAV) expAData = refMem[curCmd.addr];
            if (expBV) expBData = refMem[curCmd.addr];
            nxt = '0;
            if (burstLeft > 0) begin
                nxt.valid = 1'b1; nxt.we = burstWe; nxt.ownerB = 1'b1;
                nxt.last = (burstLeft == 1); nxt.addr = burstAddr; nxt.data = bus.b_wdata;
                burstAddr = burstAddr + 16'd1;
                burstLeft--;
            end else if (ga) begin
                nxt.valid = 1'b1; nxt.we = bus.a_we; nxt.addr = bus.a_addr; nxt.data = bus.a_wdata;
            end else if (gb) begin
                nxt.valid = 1'b1; nxt.we = bus.b_we; nxt.ownerB = 1'b1;
                nxt.last = (bus.b_len == 2'd0); nxt.addr = bus.b_addr; nxt.data = bus.b_wdata;
                burstLeft = int'(bus.b_len);
                burstAddr = bus.b_addr + 16'd1;
                burstWe   = bus.b_we;
            end
            if (!bus.b_req || gb) waitCnt = 0;
            else if (ga && waitCnt < LIMIT) waitCnt++;
            curCmd = nxt;
        end
        modelReady = 1;
    end

    // Event logs consumed by the directed checks
    logic [15:0] wrAddrQ[$], wrDataQ[$], aRdQ[$], bRdQ[$];
    int          wrCycQ[$], aRdCycQ[$], bRdCycQ[$];
    int          doneCount, busyCount, bGntCount, bRvCount;

    task automatic clearLogs();
        wrAddrQ.delete(); wrDataQ.delete(); aRdQ.delete(); bRdQ.delete();
        wrCycQ.delete(); aRdCycQ.delete(); bRdCycQ.delete();
        doneCount = 0; busyCount = 0; bGntCount = 0; bRvCount = 0;
    endtask

    always @(negedge clk) begin
        logic ga, gb, re, we;
        #2;
        if (modelReady) begin
            modelGrants(ga, gb);
            re = curCmd.valid && !curCmd.we;
            we = curCmd.valid && curCmd.we;
            checkOutput("a_gnt", bus.a_gnt, ga);
            checkOutput("b_gnt", bus.b_gnt, gb);
            checkOutput("mem_read_enable", bus.mem_read_enable, re);
            checkOutput("mem_write_enable", bus.mem_write_enable, we);
            if (re) checkOutput("mem_read_addr", bus.mem_read_addr, curCmd.addr);
            if (we) checkOutput("mem_write_addr", bus.mem_write_addr, curCmd.addr);
            if (we) checkOutput("mem_write_data", bus.mem_write_data, curCmd.data);
            checkOutput("a_rvalid", bus.a_rvalid, expAV);
            checkOutput("b_rvalid", bus.b_rvalid, expBV);
            if (expAV) checkOutput("a_rdata", bus.a_rdata, expAData);
            if (expBV) checkOutput("b_rdata", bus.b_rdata, expBData);
            checkOutput("b_done", bus.b_done, expDone);
            checkOutput("busy", bus.busy, burstLeft > 0);
            if (bus.mem_write_enable) begin
                wrAddrQ.push_back(bus.mem_write_addr);
                wrDataQ.push_back(bus.mem_write_data);
                wrCycQ.push_back(cyc);
            end
            if (bus.a_rvalid) begin aRdQ.push_back(bus.a_rdata); aRdCycQ.push_back(cyc); end
            if (bus.b_rvalid) begin bRdQ.push_back(bus.b_rdata); bRdCycQ.push_back(cyc); bRvCount++; end
            if (bus.b_done) doneCount++;
            if (bus.busy)   busyCount++;
            if (bus.b_gnt)  bGntCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic aReq, input logic aWe, input logic [15:0] aAddr,
                                 input logic [15:0] aWdata, input logic bReq, input logic bWe,
                                 input logic [15:0] bAddr, input logic [1:0] bLen, input logic [15:0] bWdata);
        bus.a_req = aReq; bus.a_we = aWe; bus.a_addr = aAddr; bus.a_wdata = aWdata;
        bus.b_req = bReq; bus.b_we = bWe; bus.b_addr = bAddr; bus.b_len = bLen; bus.b_wdata = bWdata;
    endtask

    task automatic doA(input logic we, input logic [15:0] addr, input logic [15:0] data, output int gntCyc);
        bit done = 0;
        gntCyc = -1;
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            if (bus.a_gnt) begin gntCyc = cyc; done = 1; end
            tick();
        end
        bus.a_req = 1'b0;
        checkOutput("a_grant_seen", done, 1);
    endtask

    // stopAt: beat index during which reset is pulled low (-1 for none)
    task automatic doB(input logic we, input logic [15:0] addr, input logic [1:0] len,
                       input logic [63:0] beats, input int stopAt, input bit holdA);
        int beat = 0;
        bit done = 0;
        bit gntNow, hitReset;
        bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_len = len; bus.b_wdata = beats[15:0];
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            gntNow   = bus.b_gnt;
            hitReset = gntNow && (beat == stopAt);
            if (hitReset) rst = 1'b0;
            tick();
            if (gntNow) begin
                bus.b_req = 1'b0;
                if (holdA && beat == 0) begin bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0001; end
                beat++;
                if (hitReset) begin rst = 1'b1; done = 1; end
                else if (beat > int'(len)) done = 1;
                else bus.b_wdata = beats[16*beat +: 16];
            end
        end
        bus.b_req = 1'b0;
        checkOutput("b_burst_finished", done, 1);
    endtask

    logic [15:0] expWrAddr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int g1, g2, aWins;
        bit bWon;
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks", checkCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g1, g2, aWins;
        bit bWon;
        for (int i = 0; i < 65536; i++) begin memArr[i] = '0; refMem[i] = '0; end
        memArr[16'h0010] = 16'hBEEF; refMem[16'h0010] = 16'hBEEF;
        memArr[16'h0011] = 16'hCAFE; refMem[16'h0011] = 16'hCAFE;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clearLogs();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #2;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_mem_we", bus.mem_write_enable, 0);
        checkOutput("reset_mem_re", bus.mem_read_enable, 0);
        checkOutput("reset_a_rvalid", bus.a_rvalid, 0);
        checkOutput("reset_b_done", bus.b_done, 0);
        checkOutput("reset_a_rdata", bus.a_rdata, 0);
        checkOutput("reset_b_rdata", bus.b_rdata, 0);
        tick();

        $display("[TB] A write then back-to-back read");
        clearLogs();
        doA(1'b1, 16'h00A5, 16'h1234, g1);
        doA(1'b0, 16'h00A5, 16'h0000, g2);
        tick(); tick(); tick();
        checkOutput("t1_back_to_back", g2 - g1, 1);
        checkOutput("t1_wr_count", wrAddrQ.size(), 1);
        checkOutput("t1_wr_addr", wrAddrQ[0], 16'h00A5);
        checkOutput("t1_wr_data", wrDataQ[0], 16'h1234);
        checkOutput("t1_wr_latency", wrCycQ[0] - g1, 1);
        checkOutput("t1_rd_count", aRdQ.size(), 1);
        checkOutput("t1_rd_data", aRdQ[0], 16'h1234);
        checkOutput("t1_rd_latency", aRdCycQ[0] - g2, 2);
        checkOutput("t1_no_b_rvalid", bRvCount, 0);

        $display("[TB] A and B collide, A wins");
        clearLogs();
        applyStimulus(1, 0, 16'h0010, 0, 1, 0, 16'h0011, 2'd0, 0);
        #2;
        checkOutput("t2_a_wins", bus.a_gnt, 1);
        checkOutput("t2_b_waits", bus.b_gnt, 0);
        tick();
        bus.a_req = 1'b0;
        #2;
        checkOutput("t2_b_next", bus.b_gnt, 1);
        tick();
        bus.b_req = 1'b0;
        tick(); tick(); tick();
        checkOutput("t2_a_data", aRdQ[0], 16'hBEEF);
        checkOutput("t2_b_data", bRdQ[0], 16'hCAFE);
        checkOutput("t2_done", doneCount, 1);

        $display("[TB] B write burst across address wrap");
        clearLogs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doB(1'b1, 16'hFFFE, 2'd3, 64'h0004_0003_0002_0001, -1, 1'b1);
        doA(1'b0, 16'h0001, 16'h0000, g1);
        tick(); tick(); tick();
        checkOutput("t3_wr_count", wrAddrQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_wr_addr", wrAddrQ[i], expWrAddr[i]);
            checkOutput("t3_wr_data", wrDataQ[i], 16'(i + 1));
            checkOutput("t3_wr_cycle", wrCycQ[i] - wrCycQ[0], i);
        end
        checkOutput("t3_b_gnt_cycles", bGntCount, 4);
        checkOutput("t3_done_pulses", doneCount, 1);
        checkOutput("t3_busy_cycles", busyCount, 3);
        checkOutput("t3_a_readback", aRdQ[0], 16'h0004);

        $display("[TB] starvation guard");
        clearLogs();
        aWins = 0;
        bWon  = 0;
        applyStimulus(1, 0, 16'h0010, 0, 1, 0, 16'h0011, 2'd0, 0);
        for (int i = 0; i < 20 && !bWon; i++) begin
            #2;
            if (bus.b_gnt) bWon = 1;
            else if (bus.a_gnt) aWins++;
            tick();
        end
        checkOutput("t4_b_won", bWon, 1);
        checkOutput("t4_a_wins_before_b", aWins, 8);
        #2;
        checkOutput("t4_counter_cleared_a", bus.a_gnt, 1);
        checkOutput("t4_counter_cleared_b", bus.b_gnt, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        $display("[TB] B read burst of two beats");
        clearLogs();
        doB(1'b0, 16'h0010, 2'd1, 64'h0, -1, 1'b0);
        tick(); tick(); tick();
        checkOutput("t5_rd_count", bRdQ.size(), 2);
        checkOutput("t5_rd0", bRdQ[0], 16'hBEEF);
        checkOutput("t5_rd1", bRdQ[1], 16'hCAFE);
        checkOutput("t5_consecutive", bRdCycQ[1] - bRdCycQ[0], 1);
        checkOutput("t5_done", doneCount, 1);

        $display("[TB] reset during a burst");
        clearLogs();
        doB(1'b1, 16'h0100, 2'd3, 64'h0044_0033_0022_0011, 2, 1'b0);
        #2;
        checkOutput("t6_mem_we_low", bus.mem_write_enable, 0);
        checkOutput("t6_mem_re_low", bus.mem_read_enable, 0);
        checkOutput("t6_busy_low", bus.busy, 0);
        tick(); tick(); tick();
        checkOutput("t6_no_done", doneCount, 0);
        checkOutput("t6_beats_written", wrAddrQ.size(), 2);
        doA(1'b1, 16'h0200, 16'h5555, g1);
        doA(1'b0, 16'h0200, 16'h0000, g2);
        tick(); tick(); tick();
        checkOutput("t6_a_after_reset", aRdQ.size() > 0 ? aRdQ[aRdQ.size() - 1] : 16'h0000, 16'h5555);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 16-bit data memory between two requesters. Requester A is the pipeline MEM stage (single-word accesses). Requester B is the interrupt/context-save engine (multi-word bursts, e.g. PC and flags push/pop).
- Sits between those requesters and the data memory. Drives its read/write enables and addresses, and routes returned read data back to the requester that issued the read.
- Uses fixed priority to A, with a starvation guard for B and burst locking.

Parameters:
- AW, 16, address width
- DW, 16, data width
- LEN_W, 2, burst length field width (burst = b_len+1 beats, max 4)
- STARVE_LIMIT, 8, consecutive cycles B may wait while A is granted before B wins a tie

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- a_req  in  1  A access request, held until granted
- a_we  in  1  1=write, 0=read
- a_addr  in  AW  A word address
- a_wdata  in  DW  A write data
- a_gnt  out  1  combinational; access accepted at the edge where a_req&a_gnt
- a_rvalid  out  1  registered, one-cycle pulse with read data
- a_rdata  out  DW  A read data, valid when a_rvalid
- b_req  in  1  B burst request, held until first beat granted
- b_we  in  1  burst direction
- b_addr  in  AW  burst base address
- b_len  in  LEN_W  beats minus one
- b_wdata  in  DW  current beat write data, must be valid while b_gnt
- b_gnt  out  1  combinational; high for every beat issued (beat pop strobe)
- b_rvalid  out  1  registered per-beat read data strobe
- b_rdata  out  DW  B read data
- b_done  out  1  registered one-cycle pulse after last beat issued
- mem_read_enable  out  1  memory read enable
- mem_write_enable  out  1  memory write enable
- mem_read_addr  out  AW  memory read address
- mem_write_addr  out  AW  memory write address
- mem_write_data  out  DW  memory write data
- mem_read_data  in  DW  memory read data (memory captures on falling clk)
- busy  out  1  high while in B_BURST

Behaviour:
- Reset (rst=0 at rising edge): state=IDLE. All mem_* enables=0, addrs/data=0. a_rvalid, b_rvalid, b_done, busy=0. rdata regs=0. Starvation counter=0. Burst registers cleared.
- States:
  - IDLE: one access per cycle, arbitrated.
  - B_BURST: remaining beats of a locked burst.
- IDLE grant rule:
  - a_gnt = a_req & !(b_req & starve_cnt==STARVE_LIMIT).
  - b_gnt = b_req & !a_gnt.
- Memory command timing:
  - Accepted access at edge k registers the mem_* command, which is driven during cycle k..k+1.
  - Memory performs the write at edge k+1.
  - Memory read data appears on mem_read_data at the falling edge inside that cycle.
  - The owner's rvalid/rdata is registered at edge k+1 and high for exactly one cycle.
- Idle cycles: with no access accepted, enables=0 the next cycle. The memory returns X on non-read cycles; rvalid must stay 0.
- Read-data owner: an owner tag is registered alongside the read command. rdata is steered by that tag only; the other requester's rvalid stays 0.
- Burst acceptance in IDLE (b_gnt at edge k):
  - Beat 0 is issued using b_addr/b_wdata.
  - If b_len>0: latch b_addr+1, remaining count=b_len, we; go to B_BURST.
  - If b_len==0: stay IDLE and pulse b_done at k+1.
- B_BURST:
  - Each cycle issues one beat at the internal address, with b_gnt=1 and a_gnt=0.
  - Address increments modulo 2^AW (wraps 0xFFFF->0x0000).
  - On the last beat, go to IDLE; b_done pulses at the following edge.
  - b_req/b_addr/b_len are ignored while in B_BURST.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle with b_req&a_gnt.
  - Clears on any B acceptance or when b_req=0.
- Back-to-back write then read to the same address returns the new data (write at edge k+1, read sampled at the following falling edge).
- Reset mid-burst: remaining beats are dropped, no b_done, enables low at the next cycle.
- No address range checking: addresses beyond memory depth pass through.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, B_BURST}
  - owner enum {OWN_A, OWN_B}
  - STARVE_LIMIT default
- One sub-module, dmem_burst_ctr: burst address incrementer plus remaining-beat counter, with a last-beat flag.
- The arbitration FSM and starvation counter stay in the top module.

Test Plan:
- A write 0x00A5<-0x1234, then A read 0x00A5 -> mem_write_enable one cycle after acceptance; a_rvalid exactly 2 edges after read acceptance with a_rdata=0x1234; b_rvalid=0.
- Simultaneous a_req read and b_req with starve_cnt<limit -> a_gnt=1, b_gnt=0; B granted next cycle once a_req drops.
- B write burst b_addr=0xFFFE, b_len=3, data 1,2,3,4 -> writes to FFFE, FFFF, 0000, 0001 on consecutive cycles; b_gnt high 4 cycles; a_gnt=0 throughout despite a_req=1; single b_done pulse; busy high 3 cycles.
- a_req held high continuously, b_req high -> after 8 waiting cycles, B wins; starve counter returns to 0.
- B read burst len 1 from 0x0010/0x0011 preloaded 0xBEEF/0xCAFE -> b_rvalid on two consecutive cycles with those values, in order.
- rst=0 asserted during beat 2 of a 4-beat burst -> enables 0 next cycle, no b_done, state IDLE; new A request served normally after release.
